mem_arb: RTL and testbench
==========================

# mem_arb

Two-port memory bus arbiter that shares a single 1024-bit line-wide memory port between a hart's instruction-refill bus (L1i miss) and its data bus (L1d refill/writeback). It sits between the hart and the system memory/L2 interface. Requests are registered, served one at a time with round-robin priority, and completed with a one-cycle data-valid pulse routed back to the owning requester.

## Interface

- LINE_W, 1024: line width in bits, for both read and write data.
- ADDR_W, 64: address width.
- OFFS_W, 7: line offset bits. Forced to zero on `m_addr`.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_addr  in  ADDR_W  instruction refill address.
- i_rd  in  1  instruction refill request; level, held until `i_dv`.
- i_data  out  LINE_W  refill line to L1i.
- i_dv  out  1  instruction data valid; one-cycle pulse.
- d_addr  in  ADDR_W  data-side address.
- d_rd  in  1  data line read request; level, held until `d_dv`.
- d_wr  in  1  data line write request; level, held until `d_dv`.
- d_wdata  in  LINE_W  write line from L1d.
- d_rdata  out  LINE_W  read line to L1d.
- d_dv  out  1  data-side completion for both read and write; one-cycle pulse.
- m_addr  out  ADDR_W  memory address, line-aligned.
- m_rd  out  1  memory read strobe; level.
- m_wr  out  1  memory write strobe; level.
- m_wdata  out  LINE_W  memory write line.
- m_rdata  in  LINE_W  memory read line; valid while `m_dv`=1.
- m_dv  in  1  memory completion, one cycle, for both reads and writes.

## Operation

- FSM states are IDLE, BUSY and RESP. A `last` bit records the last owner (0 = I, 1 = D).
- **IDLE:** arbitrate using `req_i = i_rd` and `req_d = d_rd | d_wr`.
  - Only one request: grant it.
  - Both requests: grant the port opposite to `last`.
  - On grant, register the following and go to BUSY:
    - `own`, `last <= own`;
    - `m_addr <= {addr[ADDR_W-1:OFFS_W], 0}`;
    - `m_rd`/`m_wr`;
    - `m_wdata <= d_wdata` (for a write).
  - No request: stay in IDLE.
- **Data-side op select:** `d_wr` takes precedence when `d_rd` and `d_wr` are both 1. The operation is a write with `m_wr`=1 and `m_rd`=0.
- **BUSY:**
  - `m_addr`, `m_rd`, `m_wr` and `m_wdata` are held constant.
  - Requester inputs are ignored.
  - On `m_dv`=1:
    - register `m_rdata` into the owner's data output;
    - assert the owner's dv for the next cycle;
    - clear `m_rd`/`m_wr`;
    - go to RESP.
- **RESP:**
  - The owner's dv is 1 for exactly this cycle. For a write, `d_rdata` is unchanged.
  - Unconditionally return to IDLE.
  - Requests are not sampled in this cycle, so the requester has time to drop its level request.
- **`m_dv` outside BUSY:** ignored, with no state change.
- **Data outputs:** `i_data` and `d_rdata` hold their last value until overwritten by a new completion to that port.

## Timing

- **Reset values** (on `rst`=1, asynchronous):
  - state = IDLE, `last` = 1 (so I wins the first tie);
  - `m_rd` = `m_wr` = 0, `i_dv` = `d_dv` = 0;
  - `m_addr` = 0, `m_wdata` = 0, `i_data` = 0, `d_rdata` = 0.
- **Reset mid-transaction:** the transaction is abandoned with no dv pulse, and a late `m_dv` is ignored.
- **Cycle timeline:**
  - Cycle 0: request seen in IDLE.
  - Cycle 1: `m_rd`/`m_wr` high (BUSY).
  - Cycle k≥1: first cycle `m_dv` can be accepted.
  - Cycle k+1: dv pulse (RESP).
  - Cycle k+2: IDLE, next arbitration.
- **Latency:** minimum request-to-dv latency is 2 cycles (`m_dv` in cycle 1). Minimum back-to-back issue spacing is 3 cycles.
- **Strobe shape:** strobes are registered outputs. `m_rd`/`m_wr` are never both 1, and never 1 outside BUSY.
- **dv pulses:** `i_dv` and `d_dv` are never 1 simultaneously, and never longer than one cycle.
- **Fairness:** under continuous contention, ownership strictly alternates I, D, I, D.

## Test plan

- **Single I refill:** `i_rd`=1, `i_addr`=0x1234_5678_9ABC_DEF5, memory returns `m_dv` 3 cycles after `m_rd` with `m_rdata`=pattern A.
  - Expect `m_addr`=0x1234_5678_9ABC_DE80 and `m_rd`=1 for 3 cycles.
  - Expect `i_dv` one cycle with `i_data`=A, and `d_dv` stays 0.
- **Data write:** `d_wr`=1, `d_addr`=0x8000_0100, `d_wdata`=pattern B, `m_dv` 1 cycle after the strobe.
  - Expect `m_wr`=1, `m_rd`=0, `m_wdata`=B and `m_addr`=0x8000_0100.
  - Expect a `d_dv` pulse with `d_rdata` unchanged.
- **Contention from reset:** `i_rd` and `d_rd` both held high.
  - Expect grant order I, D, I.
  - Expect dv pulses alternating `i_dv`, `d_dv`, `i_dv`, spaced k+2 cycles apart.
- **rd+wr conflict:** `d_rd`=`d_wr`=1.
  - Expect `m_wr`=1 and `m_rd`=0.
- **Spurious `m_dv`:** `m_dv` pulsed in IDLE and in RESP.
  - Expect no dv output, no state change and data outputs unchanged.
- **Reset mid-BUSY:** assert `rst` for 1 cycle while `m_rd`=1, then pulse `m_dv`.
  - Expect all outputs 0 immediately and no `i_dv`/`d_dv` pulse.
  - Expect a fresh `i_rd` afterwards to be granted normally.

Source files
------------

// File: rtl/mem_arb.sv
// Arbitrates one line-wide memory port between the I-refill and D refill/writeback buses, round-robin on ties.
// Latency: strobe 1 cycle after request; dv pulse 1 cycle after m_dv (minimum 2 cycles request-to-dv).
// Backpressure: requests are level-held until their dv; one transaction in flight, requests ignored outside IDLE.
module mem_arb #(
    parameter int LINE_W = 1024,
    parameter int ADDR_W = 64,
    parameter int OFFS_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_rd,
    output logic [LINE_W-1:0] i_data,
    output logic              i_dv,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_dv,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_rd,
    output logic              m_wr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_dv
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFS_W){1'b1}}, {OFFS_W{1'b0}}};

    state_t            state, state_nxt;
    logic              last;
    logic              own;
    logic              req_i, req_d, gnt_d, d_write;
    logic [ADDR_W-1:0] req_addr;

    assign req_i    = i_rd;
    assign req_d    = d_rd | d_wr;
    // On a tie the side that did not own the port last time wins.
    assign gnt_d    = req_d & (~req_i | ~last);
    assign d_write  = gnt_d & d_wr;
    assign req_addr = gnt_d ? d_addr : i_addr;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_i | req_d) state_nxt = BUSY;
            BUSY:    if (m_dv) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            own     <= 1'b0;
            m_rd    <= 1'b0;
            m_wr    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_data  <= '0;
            d_rdata <= '0;
            i_dv    <= 1'b0;
            d_dv    <= 1'b0;
        end else begin
            state <= state_nxt;
            i_dv  <= 1'b0;
            d_dv  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i | req_d) begin
                        own    <= gnt_d;
                        last   <= gnt_d;
                        m_addr <= req_addr & LINE_MASK;
                        m_wr   <= d_write;
                        m_rd   <= ~d_write;
                        if (d_write) m_wdata <= d_wdata;
                    end
                end
                BUSY: begin
                    if (m_dv) begin
                        m_rd <= 1'b0;
                        m_wr <= 1'b0;
                        if (own) begin
                            d_dv <= 1'b1;
                            // Writes complete without touching the read line.
                            if (m_rd) d_rdata <= m_rdata;
                        end else begin
                            i_dv   <= 1'b1;
                            i_data <= m_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: a scoreboard of expected completions, checked when the dv pulses appear.
module tb_mem_arb;
    localparam int LINE_W = 1024;
    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] i_addr, d_addr, m_addr;
    logic              i_rd, d_rd, d_wr, i_dv, d_dv, m_rd, m_wr, m_dv;
    logic [LINE_W-1:0] i_data, d_wdata, d_rdata, m_wdata, m_rdata;

    mem_arb #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .OFFS_W(7)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_rd(i_rd), .i_data(i_data), .i_dv(i_dv),
        .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_dv(d_dv),
        .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_dv(m_dv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              d;
        logic [LINE_W-1:0] i_data;
        logic [LINE_W-1:0] d_rdata;
    } exp_t;

    exp_t              sb[$];
    logic [LINE_W-1:0] mdl_i, mdl_d;
    int                n_pass = 0;
    int                n_total = 0;

    function automatic logic [LINE_W-1:0] pat(input logic [31:0] s);
        logic [LINE_W-1:0] p;
        for (int i = 0; i < LINE_W / 32; i++) p[i*32 +: 32] = s ^ (32'(i) * 32'h9E37_79B9);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_line(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed[95:0]=%h expected[95:0]=%h", tag, obs[95:0], exp[95:0]);
    endtask

    // Model of the data outputs; each accepted request queues the expected completion.
    task automatic push_exp(input logic d, input logic is_wr, input logic [LINE_W-1:0] rdata);
        if (!d) mdl_i = rdata;
        else if (!is_wr) mdl_d = rdata;
        sb.push_back('{d: d, i_data: mdl_i, d_rdata: mdl_d});
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_rd | m_wr) && n < 20);
        chk("strobe_seen", 64'(m_rd | m_wr), 64'd1);
    endtask

    // Called in the first BUSY cycle; returns in the RESP cycle after checking the dv pulse.
    task automatic serve(input string tag, input int lat, input int dv_len,
                         input logic [ADDR_W-1:0] ea, input logic erd, input logic ewr,
                         input logic [LINE_W-1:0] ewdata, input logic [LINE_W-1:0] rdata);
        exp_t e;
        chk({tag, "_addr"}, m_addr, ea);
        chk({tag, "_strobes"}, 64'({m_rd, m_wr}), 64'({erd, ewr}));
        if (ewr) chk_line({tag, "_wdata"}, m_wdata, ewdata);
        for (int c = 1; c < lat; c++) begin
            @(negedge clk);
            chk({tag, "_hold"}, 64'({m_rd, m_wr, i_dv, d_dv}), 64'({erd, ewr, 2'b00}));
            chk({tag, "_hold_addr"}, m_addr, ea);
        end
        m_dv    = 1'b1;
        m_rdata = rdata;
        @(negedge clk);
        if (dv_len < 2) m_dv = 1'b0;
        m_rdata = ~rdata;
        chk({tag, "_strobe_clr"}, 64'({m_rd, m_wr}), 64'd0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_dv"}, 64'({i_dv, d_dv}), 64'({~e.d, e.d}));
            chk_line({tag, "_i_data"}, i_data, e.i_data);
            chk_line({tag, "_d_rdata"}, d_rdata, e.d_rdata);
        end
        m_dv = 1'b0;
    endtask

    initial begin
        int n;
        logic [LINE_W-1:0] pa, pb, pc, p1, p2, p3;
        pa = pat(32'hA5A5_0001); pb = pat(32'hB00B_0002); pc = pat(32'hC3C3_0003);
        p1 = pat(32'h1111_0004); p2 = pat(32'h2222_0005); p3 = pat(32'h3333_0006);
        mdl_i = '0; mdl_d = '0;
        rst = 1'b1; i_rd = 0; d_rd = 0; d_wr = 0; m_dv = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 64'({m_rd, m_wr, i_dv, d_dv}), 64'd0);
        chk("rst_m_addr", m_addr, 64'd0);
        chk_line("rst_m_wdata", m_wdata, '0);
        chk_line("rst_i_data", i_data, '0);
        chk_line("rst_d_rdata", d_rdata, '0);
        rst = 1'b0;

        // Contention from reset: I wins first, then strict alternation.
        @(negedge clk);
        i_rd = 1; d_rd = 1;
        i_addr = 64'h0000_0000_0000_1000; d_addr = 64'h0000_0000_0000_2040;
        push_exp(1'b0, 1'b0, p1); push_exp(1'b1, 1'b0, p2); push_exp(1'b0, 1'b0, p3);
        wait_strobe(n);
        chk("cont_first_gap", 64'(n), 64'd1);
        serve("cont_i0", 2, 1, 64'h1000, 1'b1, 1'b0, '0, p1);
        wait_strobe(n);
        chk("cont_gap1", 64'(n), 64'd2);
        serve("cont_d1", 2, 1, 64'h2000, 1'b1, 1'b0, '0, p2);
        wait_strobe(n);
        chk("cont_gap2", 64'(n), 64'd2);
        serve("cont_i2", 2, 1, 64'h1000, 1'b1, 1'b0, '0, p3);
        i_rd = 0; d_rd = 0;
        @(negedge clk);
        chk("cont_pulse_end", 64'({i_dv, d_dv, m_rd, m_wr}), 64'd0);

        // Single I refill with an unaligned address and three BUSY cycles.
        i_rd = 1; i_addr = 64'h1234_5678_9ABC_DEF5;
        push_exp(1'b0, 1'b0, pa);
        wait_strobe(n);
        serve("irefill", 3, 1, 64'h1234_5678_9ABC_DE80, 1'b1, 1'b0, '0, pa);
        i_rd = 0;
        @(negedge clk);
        chk("irefill_pulse_end", 64'({i_dv, d_dv}), 64'd0);

        // Data write: completion pulses d_dv but leaves d_rdata alone.
        d_wr = 1; d_addr = 64'h0000_0000_8000_0100; d_wdata = pb;
        push_exp(1'b1, 1'b1, pc);
        wait_strobe(n);
        d_wdata = pc;
        serve("dwrite", 1, 1, 64'h8000_0100, 1'b0, 1'b1, pb, pc);
        d_wr = 0;
        @(negedge clk);

        // rd+wr together resolve to a write.
        d_rd = 1; d_wr = 1; d_addr = 64'h0000_0000_0000_0047; d_wdata = pc;
        push_exp(1'b1, 1'b1, pa);
        wait_strobe(n);
        serve("rdwr", 1, 1, 64'h0, 1'b0, 1'b1, pc, pa);
        d_rd = 0; d_wr = 0;
        @(negedge clk);

        // Spurious m_dv in IDLE, then held into RESP.
        m_dv = 1; m_rdata = pb;
        @(negedge clk);
        m_dv = 0;
        @(negedge clk);
        chk("spur_idle_ctrl", 64'({i_dv, d_dv, m_rd, m_wr}), 64'd0);
        chk_line("spur_idle_i_data", i_data, mdl_i);
        chk_line("spur_idle_d_rdata", d_rdata, mdl_d);
        d_rd = 1; d_addr = 64'h0000_0000_0000_3000;
        push_exp(1'b1, 1'b0, pb);
        wait_strobe(n);
        chk("spur_idle_gap", 64'(n), 64'd1);
        serve("spur_resp", 1, 2, 64'h3000, 1'b1, 1'b0, '0, pb);
        d_rd = 0;
        @(negedge clk);
        chk("spur_resp_ctrl", 64'({i_dv, d_dv, m_rd, m_wr}), 64'd0);
        chk_line("spur_resp_d_rdata", d_rdata, mdl_d);

        // Reset mid-BUSY abandons the transaction; a late m_dv is ignored.
        i_rd = 1; i_addr = 64'h0000_0000_0000_4000;
        wait_strobe(n);
        rst = 1;
        #1;
        chk("rstb_ctrl", 64'({m_rd, m_wr, i_dv, d_dv}), 64'd0);
        chk("rstb_m_addr", m_addr, 64'd0);
        chk_line("rstb_m_wdata", m_wdata, '0);
        chk_line("rstb_i_data", i_data, '0);
        chk_line("rstb_d_rdata", d_rdata, '0);
        mdl_i = '0; mdl_d = '0;
        @(negedge clk);
        rst = 0; i_rd = 0; m_dv = 1; m_rdata = pa;
        @(negedge clk);
        m_dv = 0;
        chk("rstb_late_dv", 64'({i_dv, d_dv, m_rd, m_wr}), 64'd0);
        @(negedge clk);
        chk("rstb_late_dv2", 64'({i_dv, d_dv, m_rd, m_wr}), 64'd0);
        chk_line("rstb_late_i_data", i_data, '0);
        i_rd = 1; d_rd = 1; i_addr = 64'h0000_0000_0000_5080; d_addr = 64'h0000_0000_0000_6000;
        push_exp(1'b0, 1'b0, p2);
        wait_strobe(n);
        chk("rstb_fresh_gap", 64'(n), 64'd1);
        serve("rstb_fresh", 1, 1, 64'h5080, 1'b1, 1'b0, '0, p2);
        i_rd = 0; d_rd = 0;
        @(negedge clk);
        // The D request may have been granted in that IDLE cycle; let it drain.
        if (m_rd) begin
            push_exp(1'b1, 1'b0, p3);
            serve("rstb_drain", 1, 1, 64'h6000, 1'b1, 1'b0, '0, p3);
        end
        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Pulse-shape properties checked every cycle throughout the run.
    logic prev_i_dv = 1'b0, prev_d_dv = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if ((m_rd & m_wr) | (i_dv & d_dv) | (i_dv & prev_i_dv) | (d_dv & prev_d_dv)) begin
                n_total++;
                $error("FAIL pulse_shape observed=%b expected=0000", {m_rd & m_wr, i_dv & d_dv, i_dv & prev_i_dv, d_dv & prev_d_dv});
            end
        end
        prev_i_dv <= i_dv;
        prev_d_dv <= d_dv;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
